// File: rtl/hash_check_pkg.sv
// Shared constants, state encoding and the hash step for the streaming hash checker.
// Used by tt_um_save_buffer_hash_checker and stream_hash_core.
package hash_check_pkg;

  localparam logic [7:0] SEED_DEFAULT = 8'h42;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DIGEST  = 2'd2
  } state_t;

  // uo_out readback select codes (uio_in[7:6])
  localparam logic [1:0] SEL_HASH     = 2'b00;
  localparam logic [1:0] SEL_PASS_CNT = 2'b01;
  localparam logic [1:0] SEL_FAIL_CNT = 2'b10;
  localparam logic [1:0] SEL_REM      = 2'b11;

  typedef struct packed {
    state_t     state;
    logic [7:0] rem;
    logic [7:0] hash;
  } dbg_t;

  // Mix the byte in, then fold the nibble-swapped value back onto itself.
  function automatic logic [7:0] hash_step(input logic [7:0] h, input logic [7:0] b);
    logic [7:0] m;
    m = h ^ b;
    return m ^ {m[3:0], m[7:4]};
  endfunction

endpackage

// File: rtl/stream_hash_core.sv
// Running 8-bit hash register: reloads INIT on reset or load, advances one byte when en.
// load wins over en so a frame start never mixes in a stale byte.
module stream_hash_core
  import hash_check_pkg::*;
#(
  parameter logic [7:0] INIT = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] hash
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash <= INIT;
    end else if (load) begin
      hash <= INIT;
    end else if (en) begin
      hash <= hash_step(hash, din);
    end
  end

endmodule

// File: rtl/tt_um_save_buffer_hash_checker.sv
// Receive-side checker for [LEN][payload][DIGEST] frames; reports pass/fail per frame.
// Optional saturating pass/fail counters are built when HASH_CHECK_STATS_EN is defined.
module tt_um_save_buffer_hash_checker
  import hash_check_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] PAYLOAD = ST_PAYLOAD;
  localparam logic [1:0] DIGEST  = ST_DIGEST;

  // Stream handshake: a byte on ui_in is consumed on every posedge where valid=1.
  // There is no ready; abort=1 takes precedence and drops the byte.
  logic       valid;
  logic       abort;
  logic [1:0] sel;
  assign valid = uio_in[0];
  assign abort = uio_in[1];
  assign sel   = uio_in[7:6];

  logic [1:0] state;
  logic [7:0] rem;
  logic [7:0] hash;
  logic       done;
  logic       pass;
  logic       fail;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;

  logic take;
  logic digest_take;
  logic match;
  assign take        = valid && !abort;
  assign digest_take = take && (state == DIGEST);
  assign match       = (ui_in == hash);

  stream_hash_core #(
    .INIT(SEED)
  ) u_hash (
    .clk  (clk),
    .rst_n(rst_n),
    .load (abort || (valid && state == IDLE)),
    .en   (take && state == PAYLOAD),
    .din  (ui_in),
    .hash (hash)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 8'h00;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        rem   <= 8'h00;
        pass  <= 1'b0;
        fail  <= 1'b0;
      end else if (valid) begin
        case (state)
          IDLE: begin
            pass  <= 1'b0;
            fail  <= 1'b0;
            rem   <= ui_in;
            state <= (ui_in == 8'h00) ? DIGEST : PAYLOAD;
          end
          PAYLOAD: begin
            rem <= rem - 8'd1;
            if (rem == 8'd1) state <= DIGEST;
          end
          DIGEST: begin
            pass  <= match;
            fail  <= !match;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HASH_CHECK_STATS_EN
  // Counters survive abort; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt <= 8'h00;
      fail_cnt <= 8'h00;
    end else if (digest_take) begin
      if (match && pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
      if (!match && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
    end
  end
`else
  assign pass_cnt = 8'h00;
  assign fail_cnt = 8'h00;
`endif

  always_comb begin
    uo_out = hash;
    case (sel)
      SEL_HASH:     uo_out = hash;
      SEL_PASS_CNT: uo_out = pass_cnt;
      SEL_FAIL_CNT: uo_out = fail_cnt;
      SEL_REM:      uo_out = rem;
      default:      uo_out = hash;
    endcase
  end

  assign uio_out = {2'b00, fail, pass, done, (state != IDLE), 2'b00};
  assign uio_oe  = 8'b0011_1100;

  dbg_t dbg;
  assign dbg = '{state: state_t'(state), rem: rem, hash: hash};

  logic unused;
  assign unused = &{1'b0, ena, uio_in[5:2], dbg, digest_take};

endmodule

// File: tb/tb_tt_um_save_buffer_hash_checker.sv
// Directed and randomized frame tests for tt_um_save_buffer_hash_checker against a reference model.
// Works with or without HASH_CHECK_STATS_EN defined.
module tb_tt_um_save_buffer_hash_checker;

`ifdef HASH_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int pass_m = 0;
  int fail_m = 0;
  logic [1:0] exp_q[$];
  logic [7:0] pl[$];

  tt_um_save_buffer_hash_checker dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] b, input logic v, input logic a);
    ui_in  = b;
    uio_in = {6'b000000, a, v};
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    uio_in = {sel, 6'b000000};
    #1;
    chk(tag, uo_out, exp);
  endtask

  task automatic status(input logic d, input logic p, input logic f, input logic bsy,
                        input string tag);
    chk(tag, uio_out, {2'b00, f, p, d, bsy, 2'b00});
    chk("uio_oe", uio_oe, 8'h3C);
  endtask

  // Reference hash of the first n payload bytes, straight from the arithmetic rule.
  function automatic logic [7:0] ref_hash(input int n);
    int h;
    int m;
    h = 8'h42;
    for (int i = 0; i < n; i++) begin
      m = h ^ int'(pl[i]);
      h = (m ^ ((m * 16) % 256) ^ (m / 16)) % 256;
    end
    return 8'(h);
  endfunction

  function automatic logic [7:0] cnt_exp(input int c);
    return STATS ? 8'(c) : 8'h00;
  endfunction

  // Sends one frame whose payload is in pl; checks progress and the verdict.
  task automatic frame(input int len, input logic [7:0] dig, input int gap_pct,
                       input bit idle_after, input string tag);
    logic ok;
    logic [1:0] v;
    cyc(8'(len), 1'b1, 1'b0);
    status(1'b0, 1'b0, 1'b0, 1'b1, "len_flags");
    rd(2'b11, 8'(len), "len_rem");
    for (int k = 0; k < len; k++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        cyc(8'($urandom), 1'b0, 1'b0);
        rd(2'b00, ref_hash(k), "gap_hash");
        rd(2'b11, 8'(len - k), "gap_rem");
      end
      cyc(pl[k], 1'b1, 1'b0);
      rd(2'b00, ref_hash(k + 1), "pl_hash");
      rd(2'b11, 8'(len - k - 1), "pl_rem");
    end
    ok = (dig == ref_hash(len));
    exp_q.push_back({ok, !ok});
    cyc(dig, 1'b1, 1'b0);
    if (ok) pass_m = (pass_m < 255) ? pass_m + 1 : 255;
    else    fail_m = (fail_m < 255) ? fail_m + 1 : 255;
    v = exp_q.pop_front();
    status(1'b1, v[1], v[0], 1'b0, tag);
    rd(2'b00, ref_hash(len), "final_hash");
    rd(2'b01, cnt_exp(pass_m), "pass_cnt");
    rd(2'b10, cnt_exp(fail_m), "fail_cnt");
    if (idle_after) begin
      cyc(8'($urandom), 1'b0, 1'b0);
      status(1'b0, v[1], v[0], 1'b0, "sticky");
    end
  endtask

  task automatic rand_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    int len;
    logic [7:0] dig;

    // Reset state
    rst_n = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    status(1'b0, 1'b0, 1'b0, 1'b0, "reset_flags");
    rd(2'b00, 8'h42, "reset_hash");
    rd(2'b01, 8'h00, "reset_pass_cnt");
    rd(2'b10, 8'h00, "reset_fail_cnt");
    rd(2'b11, 8'h00, "reset_rem");
    rst_n = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);

    // 1: single byte, good digest
    pl = '{8'h12};
    frame(1, 8'h55, 0, 1'b1, "t1_pass");
    rd(2'b00, 8'h55, "t1_hash55");

    // 2: computed 00, digest 01 -> fail
    pl = '{8'h00, 8'h00};
    frame(2, 8'h01, 0, 1'b1, "t2_fail");

    // 3: empty frame, then a gappy frame
    pl.delete();
    frame(0, 8'h42, 0, 1'b1, "t3_empty");
    rand_payload(4);
    frame(4, ref_hash(4), 70, 1'b1, "t3_gaps");

    // Abort in IDLE clears sticky pass
    cyc(8'h00, 1'b0, 1'b1);
    status(1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");

    // 4: abort mid-payload, with valid also high
    cyc(8'h05, 1'b1, 1'b0);
    cyc(8'hA7, 1'b1, 1'b0);
    cyc(8'h3C, 1'b1, 1'b0);
    cyc(8'h99, 1'b1, 1'b1);
    status(1'b0, 1'b0, 1'b0, 1'b0, "abort_flags");
    rd(2'b00, 8'h42, "abort_hash");
    rd(2'b11, 8'h00, "abort_rem");
    rd(2'b01, cnt_exp(pass_m), "abort_pass_cnt");
    pl = '{8'h00};
    frame(1, 8'h66, 0, 1'b1, "t4_after_abort");

    // 5a: random frames back-to-back, half with corrupted digests
    for (int f = 0; f < 30; f++) begin
      len = int'($urandom_range(0, 8));
      rand_payload(len);
      dig = ref_hash(len);
      if ($urandom_range(1) == 1) dig = dig ^ 8'($urandom_range(1, 255));
      frame(len, dig, 20, 1'b0, "rand_frame");
    end

    // 5b: many passing frames back-to-back to saturate pass_cnt
    for (int f = 0; f < 300; f++) begin
      len = int'($urandom_range(0, 2));
      rand_payload(len);
      frame(len, ref_hash(len), 0, 1'b0, "sat_frame");
    end
    rd(2'b01, STATS ? 8'hFF : 8'h00, "pass_cnt_sat");

    // 6: reset mid-payload
    cyc(8'h03, 1'b1, 1'b0);
    cyc(8'h5A, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(8'h11, 1'b1, 1'b0);
    pass_m = 0;
    fail_m = 0;
    status(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_flags");
    rd(2'b00, 8'h42, "rst_mid_hash");
    rd(2'b01, 8'h00, "rst_mid_pass_cnt");
    rd(2'b10, 8'h00, "rst_mid_fail_cnt");
    rd(2'b11, 8'h00, "rst_mid_rem");
    rst_n = 1'b1;
    pl = '{8'h12};
    frame(1, 8'h55, 0, 1'b1, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
